multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences the CPU datapath through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Consumes the decoded static controls (Branch, MemRead, MemWrite, RegWrite), the instruction opcode and the ALU branch outcome.
- Drives the per-cycle strobes: IR load, PC update, memory request/handshake, register-file write.
- Adds memory-timeout and illegal-opcode fault detection plus a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 15: max cycles mem_req may wait for mem_ready before fault (1..255).
- RETIRE_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  permits a new fetch to start.
- opcode  in  7  instruction[6:0] from the IR.
- ctl_branch  in  1  decoded Branch.
- ctl_memread  in  1  decoded MemRead.
- ctl_memwrite  in  1  decoded MemWrite.
- ctl_regwrite  in  1  decoded RegWrite.
- branch_taken  in  1  ALU branch compare result, valid in EXECUTE.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  write enable, valid with mem_req.
- mem_sel_data  out  1  0 = instruction address (PC), 1 = data address (ALU result).
- ir_load  out  1  load IR this cycle.
- pc_write  out  1  update PC this cycle.
- pc_branch  out  1  with pc_write: 1 = branch target, 0 = PC+4.
- reg_write  out  1  register-file write strobe.
- retired  out  1  one-cycle pulse per completed instruction.
- retire_count  out  RETIRE_W  retired-instruction counter.
- state  out  3  FSM state: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5.
- fault  out  1  sticky fault flag.
- fault_code  out  2  00 none, 01 illegal opcode, 10 fetch timeout, 11 data timeout.

Behaviour:
- Clock and reset: single clk domain. rst_n is asynchronous and active-low; assertion at any time, including mid-request, forces the reset values below at once.
- Reset values: state=FETCH, req_active=0, wait counter=0, retire_count=0, fault=0, fault_code=00. All strobes are 0 during reset.
- Output timing: mem_req, mem_we and mem_sel_data are registered/Moore. ir_load, pc_write, pc_branch, reg_write and retired are combinational from state, mem_ready and the ctl_* inputs.
- FETCH:
  - With run=1 and no request active, set req_active on the next edge. mem_req=1, mem_sel_data=0, mem_we=0.
  - Once raised, mem_req stays high until mem_ready, even if run drops.
  - Cycle with mem_ready=1 and mem_req=1: ir_load=1, clear req_active, go to DECODE.
  - mem_ready while mem_req=0 is ignored.
- DECODE, 1 cycle:
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011.
  - Legal: go to EXECUTE.
  - Illegal: go to HALT with fault=1, code 01.
- EXECUTE, 1 cycle:
  - ctl_branch=1: pc_write=1, pc_branch=branch_taken, retired=1, go to FETCH.
  - Else ctl_memread or ctl_memwrite: go to MEMORY.
  - Else: go to WRITEBACK.
  - ctl_memread and ctl_memwrite both set is treated as a write.
- MEMORY:
  - mem_req=1, mem_sel_data=1, mem_we=ctl_memwrite.
  - On mem_ready for a store: pc_write=1, pc_branch=0, retired=1, go to FETCH.
  - On mem_ready for a load: go to WRITEBACK.
- WRITEBACK, 1 cycle: reg_write=ctl_regwrite, pc_write=1, pc_branch=0, retired=1, go to FETCH.
- Timeout:
  - The 8-bit wait counter increments each cycle mem_req=1 and mem_ready=0. It clears on handshake or state change.
  - When the counter reaches MEM_TIMEOUT and mem_ready is still 0, go to HALT with fault_code 10 (FETCH) or 11 (MEMORY), and drop mem_req.
  - mem_ready in that same cycle wins: normal completion, no fault.
- HALT: all strobes 0, mem_req=0. Exits only on reset. fault and fault_code stay sticky.
- retire_count increments on every retired pulse and wraps from 2^RETIRE_W-1 to 0.

Test Plan:
- R-type, mem_ready immediate: states 0→1→2→4→0 over 4 cycles. reg_write=1 and pc_write=1 in WRITEBACK. retire_count=1.
- Load 0000011, data mem_ready after 3 cycles: mem_sel_data=1, mem_we=0 held 4 cycles. Then WRITEBACK with reg_write=1. Total 8 cycles.
- Branch 1100011 with branch_taken=1: EXECUTE gives pc_write=1, pc_branch=1, retired=1, back to FETCH. With branch_taken=0: pc_branch=0.
- Opcode 1111111: HALT after DECODE, fault=1, fault_code=01. run pulses do not produce mem_req. rst_n low clears everything to FETCH.
- mem_ready never asserted in FETCH, MEM_TIMEOUT=15: after 15 waiting cycles state=5, fault_code=10, mem_req=0. Repeat in MEMORY: code 11. mem_ready on the 15th cycle: no fault.
- run dropped mid-fetch: mem_req stays high until mem_ready. retire_count preloaded near 0xFFFF wraps to 0x0000 after the next retire. rst_n asserted mid-MEMORY clears mem_req asynchronously.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with
// memory-timeout and illegal-opcode fault detection and a retired-instruction counter.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int RETIRE_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [6:0]          opcode,
    input  logic                ctl_branch,
    input  logic                ctl_memread,
    input  logic                ctl_memwrite,
    input  logic                ctl_regwrite,
    input  logic                branch_taken,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_sel_data,
    output logic                ir_load,
    output logic                pc_write,
    output logic                pc_branch,
    output logic                reg_write,
    output logic                retired,
    output logic [RETIRE_W-1:0] retire_count,
    output logic [2:0]          state,
    output logic                fault,
    output logic [1:0]          fault_code
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    // The timeout fires in the cycle whose increment would reach MEM_TIMEOUT.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     st;
    logic       req_active;
    logic       we_r;
    logic       sel_r;
    logic [7:0] wait_cnt;
    logic       legal_op;
    logic       handshake;
    logic       timeout_hit;
    logic       ir_load_c;
    logic       pc_write_c;
    logic       pc_branch_c;
    logic       reg_write_c;

    assign state        = st;
    assign mem_req      = req_active;
    assign mem_we       = we_r;
    assign mem_sel_data = sel_r;
    assign handshake    = req_active && mem_ready;
    assign timeout_hit  = req_active && !mem_ready && (wait_cnt == TIMEOUT_LAST);

    always_comb begin
        legal_op = 1'b0;
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011: legal_op = 1'b1;
            default:                                                     legal_op = 1'b0;
        endcase
    end

    always_comb begin
        ir_load_c   = 1'b0;
        pc_write_c  = 1'b0;
        pc_branch_c = 1'b0;
        reg_write_c = 1'b0;
        case (st)
            S_FETCH:   ir_load_c = handshake;
            S_EXECUTE: begin
                if (ctl_branch) begin
                    pc_write_c  = 1'b1;
                    pc_branch_c = branch_taken;
                end
            end
            S_MEMORY:  pc_write_c = handshake && ctl_memwrite;
            S_WRITEBACK: begin
                reg_write_c = ctl_regwrite;
                pc_write_c  = 1'b1;
            end
            default: ;
        endcase
    end

    assign ir_load   = ir_load_c;
    assign pc_write  = pc_write_c;
    assign pc_branch = pc_branch_c;
    assign reg_write = reg_write_c;
    assign retired   = pc_write_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= S_FETCH;
            req_active   <= 1'b0;
            we_r         <= 1'b0;
            sel_r        <= 1'b0;
            wait_cnt     <= '0;
            retire_count <= '0;
            fault        <= 1'b0;
            fault_code   <= 2'b00;
        end else begin
            if (pc_write_c)
                retire_count <= retire_count + 1'b1;

            case (st)
                S_FETCH: begin
                    if (!req_active) begin
                        wait_cnt <= '0;
                        if (run) begin
                            req_active <= 1'b1;
                            sel_r      <= 1'b0;
                            we_r       <= 1'b0;
                        end
                    end else if (mem_ready) begin
                        req_active <= 1'b0;
                        wait_cnt   <= '0;
                        st         <= S_DECODE;
                    end else if (timeout_hit) begin
                        req_active <= 1'b0;
                        wait_cnt   <= '0;
                        fault      <= 1'b1;
                        fault_code <= 2'b10;
                        st         <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (legal_op) begin
                        st <= S_EXECUTE;
                    end else begin
                        fault      <= 1'b1;
                        fault_code <= 2'b01;
                        st         <= S_HALT;
                    end
                end
                S_EXECUTE: begin
                    if (ctl_branch) begin
                        st <= S_FETCH;
                    end else if (ctl_memread || ctl_memwrite) begin
                        req_active <= 1'b1;
                        sel_r      <= 1'b1;
                        we_r       <= ctl_memwrite;
                        wait_cnt   <= '0;
                        st         <= S_MEMORY;
                    end else begin
                        st <= S_WRITEBACK;
                    end
                end
                S_MEMORY: begin
                    if (mem_ready) begin
                        req_active <= 1'b0;
                        sel_r      <= 1'b0;
                        we_r       <= 1'b0;
                        wait_cnt   <= '0;
                        st         <= ctl_memwrite ? S_FETCH : S_WRITEBACK;
                    end else if (timeout_hit) begin
                        req_active <= 1'b0;
                        sel_r      <= 1'b0;
                        we_r       <= 1'b0;
                        wait_cnt   <= '0;
                        fault      <= 1'b1;
                        fault_code <= 2'b11;
                        st         <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WRITEBACK: st <= S_FETCH;
                S_HALT:      st <= S_HALT;
                default:     st <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer; a 3-bit retire counter makes the wrap reachable.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [6:0] opcode;
    logic       ctl_branch, ctl_memread, ctl_memwrite, ctl_regwrite;
    logic       branch_taken, mem_ready;
    logic       mem_req, mem_we, mem_sel_data, ir_load, pc_write, pc_branch;
    logic       reg_write, retired, fault;
    logic [2:0] retire_count;
    logic [2:0] state;
    logic [1:0] fault_code;

    int n_vec = 0;
    int n_bad = 0;

    multicycle_sequencer #(.MEM_TIMEOUT(15), .RETIRE_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
        .ctl_branch(ctl_branch), .ctl_memread(ctl_memread), .ctl_memwrite(ctl_memwrite),
        .ctl_regwrite(ctl_regwrite), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel_data(mem_sel_data), .ir_load(ir_load),
        .pc_write(pc_write), .pc_branch(pc_branch), .reg_write(reg_write), .retired(retired),
        .retire_count(retire_count), .state(state), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Starts in FETCH idle; returns one cycle after DECODE with controls applied.
    task automatic fetch_decode(input logic [6:0] op, input logic br, input logic mr,
                                input logic mw, input logic rw, input logic bt);
        run = 1'b1;
        step();
        run = 1'b0;
        check("fetch_req", 32'(mem_req), 1);
        check("fetch_sel", 32'(mem_sel_data), 0);
        mem_ready = 1'b1;
        #1;
        check("ir_load", 32'(ir_load), 1);
        step();
        mem_ready    = 1'b0;
        opcode       = op;
        ctl_branch   = br;
        ctl_memread  = mr;
        ctl_memwrite = mw;
        ctl_regwrite = rw;
        branch_taken = bt;
        check("decode_state", 32'(state), 1);
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_code", 32'(fault_code), 0);
        check("rst_req", 32'(mem_req), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; opcode = '0; ctl_branch = 1'b0; ctl_memread = 1'b0;
        ctl_memwrite = 1'b0; ctl_regwrite = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0;
        #1;
        check("reset_state", 32'(state), 0);
        check("reset_req", 32'(mem_req), 0);
        check("reset_count", 32'(retire_count), 0);
        check("reset_pcw", 32'(pc_write), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // mem_ready without a request is ignored
        mem_ready = 1'b1;
        #1;
        check("stray_ready_irload", 32'(ir_load), 0);
        step();
        mem_ready = 1'b0;
        check("stray_ready_state", 32'(state), 0);
        check("stray_ready_req", 32'(mem_req), 0);

        // R-type
        fetch_decode(7'b0110011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("r_exec", 32'(state), 2);
        check("r_exec_pcw", 32'(pc_write), 0);
        step();
        check("r_wb", 32'(state), 4);
        check("r_wb_regw", 32'(reg_write), 1);
        check("r_wb_pcw", 32'(pc_write), 1);
        check("r_wb_pcb", 32'(pc_branch), 0);
        check("r_wb_ret", 32'(retired), 1);
        step();
        check("r_done", 32'(state), 0);
        check("r_count", 32'(retire_count), 1);

        // Load with data ready on the 4th MEMORY cycle
        fetch_decode(7'b0000011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("ld_mem_state", 32'(state), 3);
            check("ld_mem_req", 32'(mem_req), 1);
            check("ld_mem_sel", 32'(mem_sel_data), 1);
            check("ld_mem_we", 32'(mem_we), 0);
            if (i < 3) step();
        end
        mem_ready = 1'b1;
        #1;
        check("ld_mem_pcw", 32'(pc_write), 0);
        step();
        mem_ready = 1'b0;
        check("ld_wb", 32'(state), 4);
        check("ld_wb_req", 32'(mem_req), 0);
        check("ld_wb_regw", 32'(reg_write), 1);
        step();
        check("ld_count", 32'(retire_count), 2);

        // Branches, taken then not taken
        fetch_decode(7'b1100011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("bt_pcw", 32'(pc_write), 1);
        check("bt_pcb", 32'(pc_branch), 1);
        check("bt_ret", 32'(retired), 1);
        step();
        check("bt_state", 32'(state), 0);
        fetch_decode(7'b1100011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bn_pcw", 32'(pc_write), 1);
        check("bn_pcb", 32'(pc_branch), 0);
        step();
        check("bn_count", 32'(retire_count), 4);

        // Store with both memread and memwrite set: treated as write
        fetch_decode(7'b0100011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("st_state", 32'(state), 3);
        check("st_we", 32'(mem_we), 1);
        mem_ready = 1'b1;
        #1;
        check("st_pcw", 32'(pc_write), 1);
        check("st_pcb", 32'(pc_branch), 0);
        check("st_regw", 32'(reg_write), 0);
        step();
        mem_ready = 1'b0;
        check("st_done", 32'(state), 0);
        check("st_count", 32'(retire_count), 5);

        // run dropped mid-fetch: request is held
        run = 1'b1;
        step();
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_req", 32'(mem_req), 1);
        end
        mem_ready = 1'b1;
        #1;
        check("hold_irload", 32'(ir_load), 1);
        step();
        mem_ready = 1'b0;
        opcode = 7'b0010011; ctl_branch = 1'b0; ctl_memread = 1'b0;
        ctl_memwrite = 1'b0; ctl_regwrite = 1'b0;
        step();
        step();
        check("hold_wb_regw", 32'(reg_write), 0);
        check("hold_wb_pcw", 32'(pc_write), 1);
        step();
        check("hold_count", 32'(retire_count), 6);

        // mem_ready on the 15th waiting fetch cycle wins over timeout
        run = 1'b1;
        step();
        run = 1'b0;
        repeat (14) step();
        check("edge_state", 32'(state), 0);
        check("edge_req", 32'(mem_req), 1);
        mem_ready = 1'b1;
        #1;
        check("edge_irload", 32'(ir_load), 1);
        step();
        mem_ready = 1'b0;
        ctl_regwrite = 1'b1;
        check("edge_decode", 32'(state), 1);
        check("edge_fault", 32'(fault), 0);
        step();
        step();
        step();
        check("edge_count", 32'(retire_count), 7);

        // 3-bit retire counter wraps 7 -> 0
        fetch_decode(7'b0110011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check("wrap_ret", 32'(retired), 1);
        step();
        check("wrap_count", 32'(retire_count), 0);

        // Data memory timeout
        fetch_decode(7'b0000011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        repeat (14) step();
        check("dto_pre_state", 32'(state), 3);
        check("dto_pre_req", 32'(mem_req), 1);
        step();
        check("dto_state", 32'(state), 5);
        check("dto_fault", 32'(fault), 1);
        check("dto_code", 32'(fault_code), 3);
        check("dto_req", 32'(mem_req), 0);
        do_reset();

        // Fetch timeout
        run = 1'b1;
        step();
        run = 1'b0;
        repeat (14) step();
        check("fto_pre_state", 32'(state), 0);
        check("fto_pre_req", 32'(mem_req), 1);
        step();
        check("fto_state", 32'(state), 5);
        check("fto_code", 32'(fault_code), 2);
        check("fto_req", 32'(mem_req), 0);
        do_reset();

        // Illegal opcode halts; run cannot restart it
        fetch_decode(7'b1111111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ill_state", 32'(state), 5);
        check("ill_fault", 32'(fault), 1);
        check("ill_code", 32'(fault_code), 1);
        run = 1'b1;
        mem_ready = 1'b1;
        repeat (3) step();
        check("ill_run_req", 32'(mem_req), 0);
        check("ill_run_irload", 32'(ir_load), 0);
        check("ill_run_state", 32'(state), 5);
        check("ill_sticky_code", 32'(fault_code), 1);
        run = 1'b0;
        mem_ready = 1'b0;
        do_reset();
        check("post_rst_count", 32'(retire_count), 0);

        // Asynchronous reset in the middle of a data request
        fetch_decode(7'b0000011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        check("mid_mem_req", 32'(mem_req), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_req", 32'(mem_req), 0);
        check("async_sel", 32'(mem_sel_data), 0);
        check("async_state", 32'(state), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
